// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter.
//   tx_state_e : transmitter FSM states
//   PAR_*      : encodings of the parity-mode input
//   clog2      : pointer/counter width helper (minimum result 1)
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read port.
//   clock, reset : clock, synchronous active-high reset (pointers/count only)
//   wr_en/wr_data: push; dropped when full (full judged on registered count)
//   rd_en/rd_data: pop; rd_data always shows the head entry
//   full, empty  : occupancy flags from the registered count
//   overflow     : high in the same cycle as a dropped push
module sync_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             overflow
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_wr;
    logic             do_rd;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_wr    = wr_en && !full;
    assign do_rd    = rd_en && !empty;
    assign overflow = wr_en && full;
    assign rd_data  = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO of payloads feeding a start/data/parity/stop
// serialiser driven by an oversample tick.
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_s_tick         : oversample tick (one-cycle pulse)
//   i_wr_en, i_data  : push a payload into the FIFO
//   i_parity_mode    : 0/3 none, 1 even, 2 odd; captured when a frame starts
//   o_tx             : registered serial line, idle high
//   o_tx_done_tick   : one-cycle pulse after the final stop tick
//   o_busy           : frame in progress
//   o_full, o_empty  : FIFO flags
//   o_overflow       : pulse when a push is dropped
// Build option: define UART_TX_PARITY_EN to enable the parity bit; otherwise
// i_parity_mode is ignored and frames never carry parity.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int OS_TICK    = 16,
    parameter int SB_TICK    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_s_tick,
    input  logic               i_wr_en,
    input  logic [NB_DATA-1:0] i_data,
    input  logic [1:0]         i_parity_mode,
    output logic               o_tx,
    output logic               o_tx_done_tick,
    output logic               o_busy,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_overflow
);

    localparam int TICK_W = clog2((OS_TICK > SB_TICK) ? OS_TICK : SB_TICK);
    localparam int BIT_W  = clog2(NB_DATA);
    localparam logic [TICK_W-1:0] OS_LAST  = TICK_W'(OS_TICK - 1);
    localparam logic [TICK_W-1:0] SB_LAST  = TICK_W'(SB_TICK - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(NB_DATA - 1);

    tx_state_e          state;
    logic [TICK_W-1:0]  tick_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [NB_DATA-1:0] shreg;
    logic [NB_DATA-1:0] fifo_data;
    logic               fifo_rd;
    logic               tx_reg;
    logic               done_reg;
    logic               os_end;

`ifdef UART_TX_PARITY_EN
    logic par_on;
    logic par_bit;
`else
    logic unused_parity_mode;
    assign unused_parity_mode = ^i_parity_mode;
`endif

    sync_fifo #(
        .WIDTH (NB_DATA),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (i_clock),
        .reset    (i_reset),
        .wr_en    (i_wr_en),
        .wr_data  (i_data),
        .rd_en    (fifo_rd),
        .rd_data  (fifo_data),
        .full     (o_full),
        .empty    (o_empty),
        .overflow (o_overflow)
    );

    // The head is popped straight out of IDLE; no tick is needed to start.
    assign fifo_rd = (state == ST_IDLE) && !o_empty;
    assign os_end  = i_s_tick && (tick_cnt == OS_LAST);

    assign o_tx           = tx_reg;
    assign o_tx_done_tick = done_reg;
    assign o_busy         = (state != ST_IDLE);

    // tx_reg is loaded with the line level of the state being entered, so the
    // pin changes on the same edge as the state and never glitches.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx_reg   <= 1'b1;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tx_reg <= 1'b1;
                    if (!o_empty) begin
                        state    <= ST_START;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        tx_reg   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (os_end) begin
                        tick_cnt <= '0;
                        state    <= ST_DATA;
                        tx_reg   <= shreg[0];
                    end else if (i_s_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (os_end) begin
                        tick_cnt <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            if (par_on) begin
                                state  <= ST_PARITY;
                                tx_reg <= par_bit;
                            end else begin
                                state  <= ST_STOP;
                                tx_reg <= 1'b1;
                            end
`else
                            state  <= ST_STOP;
                            tx_reg <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            // Next bit is shreg[1] because the shift lands on this same edge.
                            tx_reg  <= shreg[1];
                        end
                    end else if (i_s_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (os_end) begin
                        tick_cnt <= '0;
                        state    <= ST_STOP;
                        tx_reg   <= 1'b1;
                    end else if (i_s_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (i_s_tick && (tick_cnt == SB_LAST)) begin
                        tick_cnt <= '0;
                        state    <= ST_IDLE;
                        done_reg <= 1'b1;
                        tx_reg   <= 1'b1;
                    end else if (i_s_tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    tx_reg <= 1'b1;
                end
            endcase
        end
    end

    // Payload and parity are captured at pop time so later input changes
    // cannot disturb the frame in flight.
    always_ff @(posedge i_clock) begin
        if (fifo_rd) begin
            shreg <= fifo_data;
        end else if ((state == ST_DATA) && os_end) begin
            shreg <= shreg >> 1;
        end
`ifdef UART_TX_PARITY_EN
        if (fifo_rd) begin
            par_on  <= (i_parity_mode == PAR_EVEN) || (i_parity_mode == PAR_ODD);
            par_bit <= (^fifo_data) ^ (i_parity_mode == PAR_ODD);
        end
`endif
    end

endmodule
